// File: rtl/gray_pkg.sv
// Shared helpers for the Gray counter: binary/Gray conversion and a constant clog2.
// Functions work on MAX_WIDTH-bit zero-extended values, so they serve any WIDTH up to 32.
package gray_pkg;

    localparam int MAX_WIDTH = 32;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Leading zeros from zero-extension leave the low WIDTH bits of the prefix XOR unaffected.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        bin_o[WIDTH-1] = gray_i[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin_o[i] = bin_o[i+1] ^ gray_i[i];
        end
    end

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray counter with prescaler, clear/load and terminal-count pulse.
// Define COUNTER_SAT_EN to saturate at the ends instead of wrapping.
module gray_counter_param
    import gray_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             tc
);

    // A one-bit prescaler is kept for DIV=1; it simply stays at zero.
    localparam int               PW     = (DIV > 1) ? clog2(DIV) : 1;
    localparam logic [PW-1:0]    P_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] B_MAX  = '1;

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [PW-1:0]    p_q, p_d;
    logic             tc_q, tc_d;

    always_comb begin
        b_d  = b_q;
        p_d  = p_q;
        tc_d = 1'b0;
        if (clr) begin
            b_d = '0;
            p_d = '0;
        end else if (load) begin
            b_d = load_bin;
            p_d = '0;
        end else if (en) begin
            if (p_q == P_LAST) begin
                p_d = '0;
                if (up) begin
                    if (b_q == B_MAX) begin
                        tc_d = 1'b1;
`ifndef COUNTER_SAT_EN
                        b_d  = '0;
`endif
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end else begin
                    if (b_q == '0) begin
                        tc_d = 1'b1;
`ifndef COUNTER_SAT_EN
                        b_d  = B_MAX;
`endif
                    end else begin
                        b_d = b_q - 1'b1;
                    end
                end
            end else begin
                p_d = p_q + 1'b1;
            end
        end
        // Gray is registered from the next binary value so both outputs move on the same edge.
        gray_d = WIDTH'(bin2gray(MAX_WIDTH'(b_d)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q    <= '0;
            p_q    <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            b_q    <= b_d;
            p_q    <= p_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign gray = gray_q;
    assign bin  = b_q;
    assign tc   = tc_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Self-checking bench for gray_counter_param: three configurations share one stimulus stream
// and are compared against an integer reference model. Honours COUNTER_SAT_EN when defined.
module tb_gray_counter_param;

    logic       clk = 1'b0;
    logic       rst_n, en, up, clr, load;
    logic [7:0] loadBin;

    logic [4:0] gray52, bin52, gray51, bin51;
    logic [7:0] gray83, bin83, decoded83;
    logic       tc52, tc51, tc83;

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per instance: W5/D2, W5/D1, W8/D3.
    int refW[3] = '{5, 5, 8};
    int refD[3] = '{2, 1, 3};
    int refVal[3];
    int refP[3];
    int refTc[3];
    int modelNext, modelSpan;

    logic [7:0] outBin[3];
    logic [7:0] outGray[3];
    logic       outTc[3];
    logic [4:0] expSeq[5] = '{5'h00, 5'h01, 5'h03, 5'h02, 5'h06};

    int expGray;

    always #5 clk = ~clk;

    gray_counter_param #(.WIDTH(5), .DIV(2)) u_d52 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_bin(loadBin[4:0]), .gray(gray52), .bin(bin52), .tc(tc52));

    gray_counter_param #(.WIDTH(5), .DIV(1)) u_d51 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_bin(loadBin[4:0]), .gray(gray51), .bin(bin51), .tc(tc51));

    gray_counter_param #(.WIDTH(8), .DIV(3)) u_d83 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_bin(loadBin), .gray(gray83), .bin(bin83), .tc(tc83));

    gray_to_bin #(.WIDTH(8)) u_g2b (.gray_i(gray83), .bin_o(decoded83));

    always_comb begin
        outBin[0]  = {3'b000, bin52};
        outBin[1]  = {3'b000, bin51};
        outBin[2]  = bin83;
        outGray[0] = {3'b000, gray52};
        outGray[1] = {3'b000, gray51};
        outGray[2] = gray83;
        outTc[0]   = tc52;
        outTc[1]   = tc51;
        outTc[2]   = tc83;
    end

    // Behavioural model: a plain integer count modulo 2^W plus a count of enabled cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                refVal[k] = 0;
                refP[k]   = 0;
                refTc[k]  = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                modelSpan = 1 << refW[k];
                refTc[k]  = 0;
                if (clr) begin
                    refVal[k] = 0;
                    refP[k]   = 0;
                end else if (load) begin
                    refVal[k] = int'(loadBin) % modelSpan;
                    refP[k]   = 0;
                end else if (en) begin
                    if (refP[k] + 1 < refD[k]) begin
                        refP[k] = refP[k] + 1;
                    end else begin
                        refP[k]   = 0;
                        modelNext = refVal[k] + (up ? 1 : -1);
                        if (modelNext < 0 || modelNext >= modelSpan) begin
                            refTc[k] = 1;
`ifndef COUNTER_SAT_EN
                            refVal[k] = (modelNext + modelSpan) % modelSpan;
`endif
                        end else begin
                            refVal[k] = modelNext;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; loadBin = 8'd0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (outBin[k] !== 8'd0 || outGray[k] !== 8'd0 || outTc[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_inst%0d: bin=%h gray=%h tc=%b, expected 0 0 0", k, outBin[k], outGray[k], outTc[k]);
            end
        end
        rst_n = 1'b1;
        en = 1'b1;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (outBin[k] !== 8'd0 || outGray[k] !== 8'd0 || outTc[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL async_reset_inst%0d: bin=%h gray=%h tc=%b, expected 0 0 0", k, outBin[k], outGray[k], outTc[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        up = 1'b1;
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (gray52 !== expSeq[s]) begin
                errors++;
                $display("[TB] FAIL reset_seq_step%0d: gray=%h, expected %h", s, gray52, expSeq[s]);
            end
            for (int k = 0; k < 3; k++) begin
                expGray = refVal[k] ^ (refVal[k] >> 1);
                checks++;
                if (outBin[k] !== 8'(refVal[k]) || outGray[k] !== 8'(expGray) || outTc[k] !== 1'(refTc[k])) begin
                    errors++;
                    $display("[TB] FAIL reset_model_inst%0d: bin=%h gray=%h tc=%b, expected %h %h %0d", k, outBin[k], outGray[k], outTc[k], refVal[k], expGray, refTc[k]);
                end
            end
            if (s < 4) repeat (2) tick();
        end
    endtask

    task automatic test_wrap_up();
        en = 1'b0; up = 1'b1; load = 1'b1; loadBin = 8'd31;
        tick();
        load = 1'b0;
        checks++;
        if (gray51 !== 5'h10 || bin51 !== 5'd31) begin
            errors++;
            $display("[TB] FAIL wrap_up_load: gray=%h bin=%0d, expected 10 31", gray51, bin51);
        end
        en = 1'b1;
        tick();
`ifdef COUNTER_SAT_EN
        checks++;
        if (bin51 !== 5'd31 || gray51 !== 5'h10 || tc51 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_up_sat: bin=%0d gray=%h tc=%b, expected 31 10 1", bin51, gray51, tc51);
        end
        tick();
        checks++;
        if (bin51 !== 5'd31 || tc51 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_up_sat_again: bin=%0d tc=%b, expected 31 1", bin51, tc51);
        end
`else
        checks++;
        if (bin51 !== 5'd0 || gray51 !== 5'h00 || tc51 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_up: bin=%0d gray=%h tc=%b, expected 0 00 1", bin51, gray51, tc51);
        end
        tick();
        checks++;
        if (bin51 !== 5'd1 || gray51 !== 5'h01 || tc51 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_up_after: bin=%0d gray=%h tc=%b, expected 1 01 0", bin51, gray51, tc51);
        end
`endif
    endtask

    task automatic test_wrap_down();
        en = 1'b0; load = 1'b1; loadBin = 8'd0;
        tick();
        load = 1'b0; up = 1'b0; en = 1'b1;
        tick();
`ifdef COUNTER_SAT_EN
        checks++;
        if (bin51 !== 5'd0 || gray51 !== 5'h00 || tc51 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_down_sat: bin=%0d gray=%h tc=%b, expected 0 00 1", bin51, gray51, tc51);
        end
        tick();
        checks++;
        if (bin51 !== 5'd0 || tc51 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_down_sat_again: bin=%0d tc=%b, expected 0 1", bin51, tc51);
        end
`else
        checks++;
        if (bin51 !== 5'd31 || gray51 !== 5'h10 || tc51 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_down: bin=%0d gray=%h tc=%b, expected 31 10 1", bin51, gray51, tc51);
        end
        tick();
        checks++;
        if (bin51 !== 5'd30 || gray51 !== 5'h11 || tc51 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_down_after: bin=%0d gray=%h tc=%b, expected 30 11 0", bin51, gray51, tc51);
        end
`endif
    endtask

    task automatic test_priority();
        clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; loadBin = 8'd21;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (outBin[k] !== 8'd0 || outTc[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL priority_clr_inst%0d: bin=%h tc=%b, expected 0 0", k, outBin[k], outTc[k]);
            end
        end
        clr = 1'b0;
        tick();
        load = 1'b0;
        checks++;
        if (bin52 !== 5'd21 || gray52 !== 5'h1F || bin83 !== 8'd21) begin
            errors++;
            $display("[TB] FAIL priority_load: bin52=%0d gray52=%h bin83=%0d, expected 21 1f 21", bin52, gray52, bin83);
        end
        tick();
        checks++;
        if (bin52 !== 5'd21 || bin83 !== 8'd21) begin
            errors++;
            $display("[TB] FAIL priority_phase1: bin52=%0d bin83=%0d, expected 21 21", bin52, bin83);
        end
        tick();
        checks++;
        if (bin52 !== 5'd22 || bin83 !== 8'd21) begin
            errors++;
            $display("[TB] FAIL priority_phase2: bin52=%0d bin83=%0d, expected 22 21", bin52, bin83);
        end
        tick();
        checks++;
        if (bin83 !== 8'd22) begin
            errors++;
            $display("[TB] FAIL priority_phase3: bin83=%0d, expected 22", bin83);
        end
    endtask

    task automatic test_en_gaps();
        clr = 1'b1; en = 1'b0; load = 1'b0; up = 1'b1;
        tick();
        clr = 1'b0; en = 1'b1;
        tick();
        en = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (bin52 !== 5'd0 || bin83 !== 8'd0 || bin51 !== 5'd1 || tc52 !== 1'b0 || tc51 !== 1'b0 || tc83 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL en_gap_hold: bin52=%0d bin51=%0d bin83=%0d tc=%b%b%b, expected 0 1 0 000", bin52, bin51, bin83, tc52, tc51, tc83);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (bin52 !== 5'd1 || bin83 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL en_gap_resume1: bin52=%0d bin83=%0d, expected 1 0", bin52, bin83);
        end
        tick();
        checks++;
        if (bin83 !== 8'd1) begin
            errors++;
            $display("[TB] FAIL en_gap_resume2: bin83=%0d, expected 1", bin83);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] prevGray, prevBin;
        logic       stepSeen, stepWanted;
        int         enCount;
        clr = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1;
        tick();
        clr = 1'b0;
        enCount = 0;
        for (int c = 0; c < 700; c++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) up = ~up;
            prevGray = gray83;
            prevBin  = bin83;
            if (en) enCount++;
            stepWanted = en && (enCount % 3 == 0);
            tick();
            for (int k = 0; k < 3; k++) begin
                expGray = refVal[k] ^ (refVal[k] >> 1);
                checks++;
                if (outBin[k] !== 8'(refVal[k]) || outGray[k] !== 8'(expGray) || outTc[k] !== 1'(refTc[k])) begin
                    errors++;
                    $display("[TB] FAIL sweep_model_inst%0d cyc%0d: bin=%h gray=%h tc=%b, expected %h %h %0d", k, c, outBin[k], outGray[k], outTc[k], refVal[k], expGray, refTc[k]);
                end
            end
            checks++;
            if ($countones(prevGray ^ gray83) != ((bin83 !== prevBin) ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL sweep_onebit cyc%0d: gray %h -> %h, bin %h -> %h", c, prevGray, gray83, prevBin, bin83);
            end
            checks++;
            if (decoded83 !== bin83) begin
                errors++;
                $display("[TB] FAIL sweep_decode cyc%0d: decoded=%h, expected bin %h", c, decoded83, bin83);
            end
            stepSeen = (bin83 !== prevBin) || tc83;
            checks++;
            if (stepSeen !== stepWanted) begin
                errors++;
                $display("[TB] FAIL sweep_cadence cyc%0d: step=%b, expected %b", c, stepSeen, stepWanted);
            end
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_priority();
        test_en_gaps();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
